shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//  Shares the single 8-bit combinational right shifter (shift_right_8bit) between NREQ requesters.
//  Runs each shift as a multi-cycle sequence of at most STEP_MAX bits per cycle.
//  Left shifts are served by bit-reversing the operand around the right shifter.
//  Sits between the ALU issue logic (requesters) and the ALU result path (valid/ready response).
// PARAMETERS
//  NREQ      2  number of requesters, 2..4; id width IDW = $clog2(NREQ)
//  STEP_MAX  4  max shift bits applied per SHIFT cycle, 1..8
// PORTS
//  clk_i        in   1          single clock, rising edge
//  rst_ni       in   1          asynchronous active-low reset
//  req_valid_i  in   NREQ       per-requester request valid
//  req_ready_o  out  NREQ       per-requester accept (one-hot or zero)
//  req_data_i   in   NREQx8     operand per requester
//  req_amt_i    in   NREQx4     shift amount per requester, 0..15
//  req_dir_i    in   NREQ       0 = logical right, 1 = logical left
//  rsp_valid_o  out  1          result valid
//  rsp_ready_i  in   1          downstream accepts result
//  rsp_data_o   out  8          shifted result
//  rsp_id_o     out  IDW        index of the requester that owns rsp_data_o
//  busy_o       out  1          high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rst_ni=0): state=IDLE; rr pointer=0; acc, rem, id cleared.
//   Outputs after reset: req_ready_o=0 until a valid request arrives, rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, busy_o=0.
//  Reset asserted mid-operation aborts the transaction silently; no response is produced.
//  FSM states: IDLE, SHIFT, DONE (state enum in package).
//   IDLE: round-robin grant among req_valid_i, starting search at rr pointer.
//    req_ready_o[g]=1 (combinational, IDLE only) for the granted index g; all other bits are 0.
//    On handshake at edge E:
//     acc <= dir ? bitrev(data) : data.
//     rem <= min(amt,8); amounts 8..15 all yield 0x00.
//     id <= g; dirq <= dir; rr <= (g+1) mod NREQ.
//     Next state is SHIFT if rem != 0, else DONE.
//   SHIFT: step = min(rem, STEP_MAX); acc <= shr(acc, step); rem <= rem - step.
//    Go to DONE when rem - step == 0.
//   DONE: rsp_valid_o=1; rsp_data_o = dirq ? bitrev(acc) : acc; rsp_id_o = id.
//    Held stable while rsp_ready_i=0. On rsp_valid_o & rsp_ready_i, go to IDLE.
//  Latency: let N = ceil(min(amt,8)/STEP_MAX).
//   rsp_valid_o is high from edge E+N, and from edge E when amt=0.
//   Earliest next acceptance is the cycle after the response handshake (no overlap).
//  No request is accepted outside IDLE. Requests that are not granted must hold until accepted (valid/ready rules).
//  Simultaneous valids: only one grant per IDLE cycle; the rr pointer guarantees fairness.
//  rsp_data_o/rsp_id_o are registered-derived; no combinational path from req_* to rsp_*.
// STRUCTURE
//  alu_pkg: SHIFT_W=8, AMT_W=4, typedef enum logic [1:0] {IDLE,SHIFT,DONE} seq_state_e,
//   typedef enum logic {DIR_RIGHT,DIR_LEFT} shift_dir_e, function bitrev8().
//  Sub-module: one instance of shift_right_8bit (a=acc, b=step, c_o=next acc).
//  Arbiter: inline round-robin logic (small; no separate module).
// TESTING
//  1. Reset; req0: 0xB6, amt=3, right -> 1 SHIFT cycle; rsp_data=0x16, rsp_id=0.
//  2. req1: 0xFF, amt=7, right -> 2 SHIFT cycles (4+3), busy_o high 3 cycles; rsp=0x01, id=1.
//  3. req0: 0x81, amt=1, left -> rsp=0x02; then amt=12 on 0xFF -> clamped to 8, 2 SHIFT cycles, rsp=0x00.
//  4. req0 and req1 valid together from reset -> req0 is served first, then req1. Reversed order is not allowed.
//     Repeat with both valid continuously -> grants alternate 0,1,0,1.
//  5. amt=0, data 0x5A -> DONE directly; rsp_valid next cycle; rsp=0x5A.
//     Hold rsp_ready_i=0 for 5 cycles -> rsp stable, req_ready_o=0 throughout.
//  6. Assert rst_ni low during SHIFT -> outputs reset immediately. After release, no stale response appears.
//     The next request completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared types, widths and helpers for the shift sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int SHIFT_W = 8;
  localparam int AMT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } shift_dir_e;

  // Mirror an operand so a right shift of the mirror equals a left shift
  function automatic logic [SHIFT_W-1:0] bitrev8(input logic [SHIFT_W-1:0] v);
    logic [SHIFT_W-1:0] r;
    r = '0;
    for (int i = 0; i < SHIFT_W; i++) begin
      r[i] = v[SHIFT_W-1-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_right_8bit.sv
`default_nettype none
// ============================================================================
// Module   : shift_right_8bit
// Brief    : Combinational 8-bit logical right shifter (shift 0..15).
// Revision : 1.0 - initial release
// ============================================================================
module shift_right_8bit
  import alu_pkg::*;
(
  input  logic [SHIFT_W-1:0] a,
  input  logic [AMT_W-1:0]   b,
  output logic [SHIFT_W-1:0] c_o
);

  // Logical shift; amounts of 8 or more clear the operand
  assign c_o = a >> b;

endmodule
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_ctrl
// Brief    : Shares one 8-bit right shifter between NREQ requesters, running
//            each shift as a multi-cycle sequence of <= STEP_MAX bits/cycle.
//            Left shifts bit-reverse the operand around the right shifter.
// Revision : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl
  import alu_pkg::*;
#(
  parameter  int NREQ     = 2,
  parameter  int STEP_MAX = 4,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NREQ-1:0]                req_valid_i,
  output logic [NREQ-1:0]                req_ready_o,
  input  logic [NREQ-1:0][SHIFT_W-1:0]   req_data_i,
  input  logic [NREQ-1:0][AMT_W-1:0]     req_amt_i,
  input  logic [NREQ-1:0]                req_dir_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [SHIFT_W-1:0]             rsp_data_o,
  output logic [IDW-1:0]                 rsp_id_o,
  output logic                           busy_o
);

  localparam logic [AMT_W-1:0] STEP_LIM = AMT_W'(STEP_MAX);
  localparam logic [AMT_W-1:0] AMT_CLIP = AMT_W'(SHIFT_W);
  localparam logic [IDW-1:0]   LAST_ID  = IDW'(NREQ - 1);

  seq_state_e          state;
  logic [SHIFT_W-1:0]  acc;
  logic [AMT_W-1:0]    rem;
  logic [IDW-1:0]      id;
  logic [IDW-1:0]      rr;
  logic                dirq;

  logic [NREQ-1:0]     grant;
  logic                gvalid;
  logic [IDW-1:0]      gidx;
  logic [SHIFT_W-1:0]  sel_data;
  logic [AMT_W-1:0]    sel_amt;
  logic                sel_dir;
  logic [AMT_W-1:0]    amt_clip;
  logic [AMT_W-1:0]    step;
  logic [AMT_W-1:0]    rem_next;
  logic [SHIFT_W-1:0]  acc_shifted;

  // Round-robin pick: first valid at or above rr, else first valid from 0
  always_comb begin
    grant    = '0;
    gvalid   = 1'b0;
    gidx     = '0;
    sel_data = '0;
    sel_amt  = '0;
    sel_dir  = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!gvalid && req_valid_i[j] && (IDW'(j) >= rr)) begin
        gvalid   = 1'b1;
        grant[j] = 1'b1;
        gidx     = IDW'(j);
        sel_data = req_data_i[j];
        sel_amt  = req_amt_i[j];
        sel_dir  = req_dir_i[j];
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!gvalid && req_valid_i[j]) begin
        gvalid   = 1'b1;
        grant[j] = 1'b1;
        gidx     = IDW'(j);
        sel_data = req_data_i[j];
        sel_amt  = req_amt_i[j];
        sel_dir  = req_dir_i[j];
      end
    end
  end

  // Clamp the amount and size this cycle's step
  always_comb begin
    amt_clip = (sel_amt > AMT_CLIP) ? AMT_CLIP : sel_amt;
    step     = (rem > STEP_LIM) ? STEP_LIM : rem;
    rem_next = rem - step;
  end

  shift_right_8bit u_shr (
    .a   (acc),
    .b   (step),
    .c_o (acc_shifted)
  );

  // Sequencer: accept in IDLE, shift in SHIFT, present result in DONE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      id    <= '0;
      dirq  <= 1'b0;
      rr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gvalid) begin
            acc   <= (sel_dir == DIR_LEFT) ? bitrev8(sel_data) : sel_data;
            rem   <= amt_clip;
            id    <= gidx;
            dirq  <= sel_dir;
            rr    <= (gidx == LAST_ID) ? '0 : gidx + 1'b1;
            state <= (amt_clip != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          acc <= acc_shifted;
          rem <= rem_next;
          if (rem_next == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; no path from req_* to rsp_*
  always_comb begin
    req_ready_o = (state == IDLE) ? grant : '0;
    busy_o      = (state != IDLE);
    rsp_valid_o = (state == DONE);
    rsp_data_o  = '0;
    rsp_id_o    = '0;
    if (state == DONE) begin
      rsp_data_o = (dirq == DIR_LEFT) ? bitrev8(acc) : acc;
      rsp_id_o   = id;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_seq_ctrl
// Brief    : Self-checking bench for shift_seq_ctrl (scoreboard queue).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_seq_ctrl;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0][7:0] req_data = '0;
  logic [1:0][3:0] req_amt = '0;
  logic [1:0]      req_dir = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [7:0]      rsp_data;
  logic [0:0]      rsp_id;
  logic            busy;

  typedef struct {
    logic [7:0] data;
    int         id;
    int         lat;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  shift_seq_ctrl #(.NREQ(2), .STEP_MAX(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .req_amt_i   (req_amt),
    .req_dir_i   (req_dir),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id),
    .busy_o      (busy)
  );

  always #5 clk_i = ~clk_i;

  // Reference: plain shifts with the amount clamped at 8
  function automatic logic [7:0] model(input logic [7:0] d, input logic [3:0] a, input logic dir);
    int s;
    s = (a > 4'd8) ? 8 : int'(a);
    return dir ? 8'((d << s) & 8'hFF) : (d >> s);
  endfunction

  function automatic int nsteps(input logic [3:0] a);
    int s;
    s = (a > 4'd8) ? 8 : int'(a);
    return (s + 3) / 4;
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input logic [3:0] a, input logic dir, input int id);
    exp_t e;
    e.data = model(d, a, dir);
    e.id   = id;
    e.lat  = nsteps(a);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input int idx, input logic [7:0] d, input logic [3:0] a,
                      input logic dir, output bit ok);
    ok = 1'b0;
    req_valid[idx] = 1'b1;
    req_data[idx]  = d;
    req_amt[idx]   = a;
    req_dir[idx]   = dir;
    for (int c = 0; c < 50 && !ok; c++) begin
      #1;
      if (req_ready[idx]) begin
        ok = 1'b1;
        q.push_back(mk(d, a, dir, idx));
      end
      @(negedge clk_i);
    end
    req_valid[idx] = 1'b0;
  endtask

  // Waits for rsp_valid; returns 1 time unit after a negedge, cyc = negedges waited
  task automatic wait_rsp(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (rsp_valid) begin
        ok  = 1'b1;
        cyc = c;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({rsp_valid, busy, req_ready, rsp_data, rsp_id} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b busy=%b ready=%b data=%h id=%0d, want all zero",
               rsp_valid, busy, req_ready, rsp_data, rsp_id);
    end
    @(negedge clk_i);
  endtask

  // Common single-request flow with latency, data and id checks
  task automatic run_one(input string nm, input int idx, input logic [7:0] d,
                         input logic [3:0] a, input logic dir);
    bit ok;
    int cyc;
    exp_t e;
    send(idx, d, a, dir, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_accept: request never accepted, want accept", nm);
      return;
    end
    wait_rsp(ok, cyc);
    e = q.pop_front();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: no response, want data %h", nm, e.data);
    end else if (rsp_data !== e.data || int'(rsp_id) != e.id || cyc != e.lat) begin
      errors++;
      $display("FAIL %s: got data=%h id=%0d lat=%0d, want data=%h id=%0d lat=%0d",
               nm, rsp_data, rsp_id, cyc, e.data, e.id, e.lat);
    end
    @(negedge clk_i);
  endtask

  task automatic test_right_shift();
    run_one("right_b6_3", 0, 8'hB6, 4'd3, 1'b0);
  endtask

  task automatic test_multi_step();
    bit ok;
    int bcnt;
    logic [7:0] d;
    logic [0:0] idv;
    exp_t e;
    bit seen;
    bcnt = 0;
    seen = 1'b0;
    d = '0;
    idv = '0;
    send(1, 8'hFF, 4'd7, 1'b0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL multi_accept: request never accepted");
      return;
    end
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!busy) break;
      bcnt++;
      if (rsp_valid && !seen) begin
        seen = 1'b1;
        d    = rsp_data;
        idv  = rsp_id;
      end
      @(negedge clk_i);
    end
    e = q.pop_front();
    checks++;
    if (bcnt != 3) begin
      errors++;
      $display("FAIL multi_busy: busy cycles=%0d, want 3", bcnt);
    end
    checks++;
    if (!seen || d !== e.data || int'(idv) != e.id) begin
      errors++;
      $display("FAIL multi_data: got seen=%b data=%h id=%0d, want data=%h id=%0d",
               seen, d, idv, e.data, e.id);
    end
    @(negedge clk_i);
  endtask

  task automatic test_left_and_clamp();
    run_one("left_81_1", 0, 8'h81, 4'd1, 1'b1);
    run_one("clamp_ff_12", 0, 8'hFF, 4'd12, 1'b0);
    run_one("left_clamp_3c_15", 1, 8'h3C, 4'd15, 1'b1);
    run_one("left_c3_5", 1, 8'hC3, 4'd5, 1'b1);
  endtask

  task automatic test_arbitration();
    bit ok;
    int cyc;
    exp_t e;
    do_reset();
    req_data[0] = 8'hF0; req_amt[0] = 4'd4; req_dir[0] = 1'b0;
    req_data[1] = 8'h0F; req_amt[1] = 4'd2; req_dir[1] = 1'b1;
    req_valid   = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL arb_first_grant: ready=%b, want 01", req_ready);
    end
    q.push_back(mk(8'hF0, 4'd4, 1'b0, 0));
    q.push_back(mk(8'h0F, 4'd2, 1'b1, 1));
    @(negedge clk_i);
    req_valid[0] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      wait_rsp(ok, cyc);
      e = q.pop_front();
      checks++;
      if (!ok || rsp_data !== e.data || int'(rsp_id) != e.id) begin
        errors++;
        $display("FAIL arb_order_%0d: ok=%b data=%h id=%0d, want data=%h id=%0d",
                 n, ok, rsp_data, rsp_id, e.data, e.id);
      end
      @(negedge clk_i);
      if (n == 0) req_valid[1] = 1'b1;
      else req_valid[1] = 1'b0;
    end
    // Both held valid: grants must alternate starting at 0
    @(negedge clk_i);
    for (int n = 0; n < 4; n++) q.push_back(mk(req_data[n % 2], req_amt[n % 2], req_dir[n % 2], n % 2));
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      wait_rsp(ok, cyc);
      e = q.pop_front();
      checks++;
      if (!ok || rsp_data !== e.data || int'(rsp_id) != e.id) begin
        errors++;
        $display("FAIL arb_alt_%0d: ok=%b data=%h id=%0d, want data=%h id=%0d",
                 n, ok, rsp_data, rsp_id, e.data, e.id);
      end
      @(negedge clk_i);
    end
    req_valid = 2'b00;
    @(negedge clk_i);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL arb_idle: busy=%b, want 0", busy);
    end
    @(negedge clk_i);
  endtask

  task automatic test_amt_zero_hold();
    bit ok;
    int cyc;
    exp_t e;
    rsp_ready = 1'b0;
    send(0, 8'h5A, 4'd0, 1'b0, ok);
    wait_rsp(ok, cyc);
    e = q.pop_front();
    checks++;
    if (!ok || cyc != 0 || rsp_data !== e.data || int'(rsp_id) != e.id) begin
      errors++;
      $display("FAIL zero_amt: ok=%b lat=%0d data=%h id=%0d, want lat=0 data=%h id=%0d",
               ok, cyc, rsp_data, rsp_id, e.data, e.id);
    end
    @(negedge clk_i);
    req_valid[1] = 1'b1; req_data[1] = 8'h11; req_amt[1] = 4'd1; req_dir[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b data=%h ready=%b, want 1 5a 00",
                 k, rsp_valid, rsp_data, req_ready);
      end
      @(negedge clk_i);
    end
    req_valid[1] = 1'b0;
    rsp_ready    = 1'b1;
    @(negedge clk_i);
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: busy=%b valid=%b, want 0 0", busy, rsp_valid);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit stale;
    exp_t e;
    stale = 1'b0;
    send(0, 8'hFF, 4'd8, 1'b0, ok);
    if (ok) e = q.pop_front();
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: busy=%b valid=%b data=%h, want 0 0 00", busy, rsp_valid, rsp_data);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (rsp_valid || busy) stale = 1'b1;
      @(negedge clk_i);
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL mid_reset_stale: activity after reset, want none");
    end
    run_one("after_reset", 1, 8'h3C, 4'd2, 1'b1);
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_right_shift();
    test_multi_step();
    test_left_and_clamp();
    test_arbitration();
    test_amt_zero_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
